// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: shared state, condition, opcode and ALU encodings for the multicycle sequencer.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL, NV
  } cond_t;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_UND = 2'b11
  } op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;
  localparam logic [2:0] ALU_MOV = 3'b101;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  function automatic logic dp_cmd_ok(input logic [3:0] cmd);
    return cmd inside {CMD_AND, CMD_EOR, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV};
  endfunction

  function automatic logic [2:0] dp_alu(input logic [3:0] cmd);
    return (cmd == CMD_SUB || cmd == CMD_CMP) ? ALU_SUB :
           cmd == CMD_AND ? ALU_AND :
           cmd == CMD_ORR ? ALU_ORR :
           cmd == CMD_EOR ? ALU_EOR :
           cmd == CMD_MOV ? ALU_MOV : ALU_ADD;
  endfunction

endpackage

// File: rtl/instr_sequencer_cond_check.sv
// cond_check: combinational ARM condition-code evaluation against the NZCV flags.
module cond_check
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] NZCV,
  output logic       CondEx
);

  logic n, z, c, v;

  assign {n, z, c, v} = NZCV;

  always_comb begin
    case (cond_t'(cond))
      EQ:      CondEx = z;
      NE:      CondEx = ~z;
      CS:      CondEx = c;
      CC:      CondEx = ~c;
      MI:      CondEx = n;
      PL:      CondEx = ~n;
      VS:      CondEx = v;
      VC:      CondEx = ~v;
      HI:      CondEx = c & ~z;
      LS:      CondEx = ~c | z;
      GE:      CondEx = n ~^ v;
      LT:      CondEx = n ^ v;
      GT:      CondEx = ~z & (n ~^ v);
      LE:      CondEx = z | (n ^ v);
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with NZCV flags.
// Performance counters are built only when CTRL_PERF_CNT_EN is defined.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instr,
  input  logic             imem_valid,
  input  logic             dmem_ready,
  input  logic [3:0]       ALUFlags,
  output logic             fetch_req,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSrc,
  output logic [1:0]       RegSrc,
  output logic             RegWrite,
  output logic [1:0]       ImmSrc,
  output logic             ALUSrc,
  output logic [2:0]       ALUControl,
  output logic             ShiftEn,
  output logic             MemReq,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             BL,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  nzcv_q, nzcv_d;
  logic        condex_q, condex_d;
  logic        cond_ok;
  logic        ir_write, pc_write, reg_write, mem_req, mem_write;
  op_t         op;
  logic [3:0]  cmd;
  logic        l_bit, cmp, nop;
  logic        unused_ir;

  assign op        = op_t'(ir_q[27:26]);
  assign cmd       = ir_q[24:21];
  assign l_bit     = ir_q[20];
  assign cmp       = cmd == CMD_CMP;
  assign nop       = !condex_q || op == OP_UND || (op == OP_DP && !dp_cmd_ok(cmd));
  assign unused_ir = ^{ir_q[19:16], ir_q[11:0]};

  cond_check u_cond_check (
    .cond   (ir_q[31:28]),
    .NZCV   (nzcv_q),
    .CondEx (cond_ok)
  );

  assign ImmSrc = op == OP_MEM ? 2'b01 : op == OP_BR ? 2'b10 : 2'b00;
  assign RegSrc = {op == OP_MEM, op == OP_BR};

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    nzcv_d     = nzcv_q;
    condex_d   = condex_q;
    fetch_req  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    PCSrc      = 1'b0;
    reg_write  = 1'b0;
    ALUSrc     = 1'b0;
    ALUControl = ALU_ADD;
    ShiftEn    = 1'b0;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    MemtoReg   = 1'b0;
    BL         = 1'b0;
    case (state_q)
      FETCH: begin
        fetch_req = 1'b1;
        ir_write  = imem_valid;
        ir_d      = imem_valid ? Instr : ir_q;
        state_d   = imem_valid ? DECODE : FETCH;
      end
      DECODE: begin
        condex_d = cond_ok;
        state_d  = EXEC;
      end
      EXEC: begin
        ALUSrc     = op == OP_DP ? ir_q[25] : 1'b1;
        ShiftEn    = op == OP_DP && !ir_q[25];
        ALUControl = op == OP_DP ? dp_alu(cmd) : (op == OP_MEM && !ir_q[23]) ? ALU_SUB : ALU_ADD;
        if (nop) begin
          pc_write = 1'b1;
          state_d  = FETCH;
        end else if (op == OP_DP) begin
          nzcv_d   = (ir_q[20] || cmp) ? ALUFlags : nzcv_q;
          pc_write = cmp;
          state_d  = cmp ? FETCH : WB;
        end else if (op == OP_MEM) begin
          state_d = MEM;
        end else begin
          PCSrc     = 1'b1;
          pc_write  = 1'b1;
          BL        = ir_q[24];
          reg_write = ir_q[24];
          state_d   = FETCH;
        end
      end
      MEM: begin
        mem_req   = 1'b1;
        mem_write = !l_bit;
        pc_write  = dmem_ready && !l_bit;
        state_d   = !dmem_ready ? MEM : l_bit ? WB : FETCH;
      end
      WB: begin
        reg_write = 1'b1;
        MemtoReg  = op == OP_MEM;
        PCSrc     = ir_q[15:12] == 4'hF;
        pc_write  = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset suppresses every write strobe immediately, not just from the next edge.
  assign IRWrite  = reset & ir_write;
  assign PCWrite  = reset & pc_write;
  assign RegWrite = reset & reg_write;
  assign MemReq   = reset & mem_req;
  assign MemWrite = reset & mem_write;
  assign state_o  = state_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= FETCH;
      ir_q     <= '0;
      nzcv_q   <= '0;
      condex_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      nzcv_q   <= nzcv_d;
      condex_q <= condex_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d, stall_q, stall_d;

  always_comb begin
    retired_d = retired_q + CNT_W'(pc_write && condex_q);
    stall_d   = stall_q + CNT_W'((state_q == FETCH && !imem_valid) || (state_q == MEM && !dmem_ready));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized and directed checks of instr_sequencer against a cycle-trace model.
module tb_instr_sequencer;

  localparam int CNT_W = 32;

  typedef struct packed {
    logic [11:0] e;
    logic        iv;
    logic        dr;
  } cyc_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      Instr;
  logic             imem_valid, dmem_ready;
  logic [3:0]       ALUFlags;
  logic             fetch_req, IRWrite, PCWrite, PCSrc, RegWrite, ALUSrc, ShiftEn;
  logic             MemReq, MemWrite, MemtoReg, BL;
  logic [1:0]       RegSrc, ImmSrc;
  logic [2:0]       ALUControl, state_o;
  logic [CNT_W-1:0] retired_cnt, stall_cnt;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [3:0]       m_nzcv;
  logic [CNT_W-1:0] m_ret, m_stall;

  always #5 clk = ~clk;

  instr_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .imem_valid(imem_valid), .dmem_ready(dmem_ready),
    .ALUFlags(ALUFlags), .fetch_req(fetch_req), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
    .ShiftEn(ShiftEn), .MemReq(MemReq), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .BL(BL),
    .state_o(state_o), .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
  );

  // ARM encodes conditions as predicate pairs: bit 0 inverts the predicate chosen by bits 3:1.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, p;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0:    p = z;
      3'd1:    p = cy;
      3'd2:    p = n;
      3'd3:    p = v;
      3'd4:    p = cy & ~z;
      3'd5:    p = n == v;
      3'd6:    p = ~z & (n == v);
      default: p = 1'b1;
    endcase
    return c == 4'hF ? 1'b0 : p ^ c[0];
  endfunction

  function automatic logic [2:0] alu_model(input logic [3:0] cmd);
    case (cmd)
      4'b0100:          return 3'd0;
      4'b0010, 4'b1010: return 3'd1;
      4'b0000:          return 3'd2;
      4'b1100:          return 3'd3;
      4'b0001:          return 3'd4;
      default:          return 3'd5;
    endcase
  endfunction

  // Trace vector: {state, fetch_req, IRWrite, PCWrite, PCSrc, RegWrite, MemReq, MemWrite, MemtoReg, BL}
  task automatic do_instr(input logic [31:0] ins, input int fw, input int mw, input logic [3:0] fl,
                          output int lat);
    cyc_t        q[$];
    logic [1:0]  op;
    logic [3:0]  cmd;
    logic        ex, ok, cmp, l, wb, runs;
    logic [11:0] obs;
    logic [4:0]  exp_alu;
    int          dec_i, ex_i, pulses;
    op   = ins[27:26];
    cmd  = ins[24:21];
    l    = ins[20];
    ok   = cmd inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1010, 4'b1100, 4'b1101};
    cmp  = cmd == 4'b1010;
    ex   = cond_model(ins[31:28], m_nzcv);
    runs = ex && op != 2'b11 && !(op == 2'b00 && !ok);
    wb   = 1'b0;
    for (int i = 0; i < fw; i++) q.push_back({3'd0, 9'b100000000, 1'b0, 1'($urandom)});
    q.push_back({3'd0, 9'b110000000, 1'b1, 1'($urandom)});
    dec_i = q.size();
    q.push_back({3'd1, 9'b000000000, 1'($urandom), 1'($urandom)});
    ex_i = q.size();
    if (!runs) begin
      q.push_back({3'd2, 9'b001000000, 1'($urandom), 1'($urandom)});
    end else if (op == 2'b00) begin
      q.push_back({3'd2, 2'b00, cmp, 6'b000000, 1'($urandom), 1'($urandom)});
      wb = !cmp;
      if (ins[20] || cmp) m_nzcv = fl;
    end else if (op == 2'b10) begin
      q.push_back({3'd2, 2'b00, 1'b1, 1'b1, ins[24], 3'b000, ins[24], 1'($urandom), 1'($urandom)});
    end else begin
      q.push_back({3'd2, 9'b000000000, 1'($urandom), 1'($urandom)});
      for (int i = 0; i < mw; i++) q.push_back({3'd3, 5'b00000, 1'b1, ~l, 2'b00, 1'($urandom), 1'b0});
      q.push_back({3'd3, 2'b00, ~l, 2'b00, 1'b1, ~l, 2'b00, 1'($urandom), 1'b1});
      wb = l;
      m_stall += CNT_W'(mw);
    end
    if (wb) q.push_back({3'd4, 2'b00, 1'b1, ins[15:12] == 4'hF, 1'b1, 2'b00, op == 2'b01, 1'b0,
                         1'($urandom), 1'($urandom)});
    m_stall += CNT_W'(fw);
    if (ex) m_ret += 1;
    exp_alu = op == 2'b00 ? {ins[25], ~ins[25], alu_model(cmd)} :
              op == 2'b01 ? {2'b10, ins[23] ? 3'd0 : 3'd1} : 5'b10000;
    pulses = 0;
    lat    = -1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      Instr      = ins;
      imem_valid = q[i].iv;
      dmem_ready = q[i].dr;
      ALUFlags   = i == ex_i ? fl : 4'($urandom);
      #1;
      obs = {state_o, fetch_req, IRWrite, PCWrite, PCSrc, RegWrite, MemReq, MemWrite, MemtoReg, BL};
      n_cmp++;
      if (obs !== q[i].e) begin
        n_bad++;
        $display("FAIL trace ins=%h cycle=%0d got=%b want=%b", ins, i, obs, q[i].e);
      end
      if (PCWrite === 1'b1) begin
        pulses++;
        if (lat < 0) lat = i + 1;
      end
      if (i == dec_i && op != 2'b11) begin
        n_cmp++;
        if ({ImmSrc, RegSrc[0]} !== {op, op == 2'b10}) begin
          n_bad++;
          $display("FAIL decode_src ins=%h got=%b want=%b", ins, {ImmSrc, RegSrc[0]}, {op, op == 2'b10});
        end
      end
      if (i == ex_i && runs) begin
        n_cmp++;
        if ({ALUSrc, ShiftEn, ALUControl} !== exp_alu) begin
          n_bad++;
          $display("FAIL exec_alu ins=%h got=%b want=%b", ins, {ALUSrc, ShiftEn, ALUControl}, exp_alu);
        end
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_bad++;
      $display("FAIL pcwrite_count ins=%h got=%0d want=1", ins, pulses);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (state_o !== 3'd0) begin
      n_bad++;
      $display("FAIL back_to_fetch ins=%h got=%0d want=0", ins, state_o);
    end
`ifdef CTRL_PERF_CNT_EN
    n_cmp++;
    if (retired_cnt !== m_ret || stall_cnt !== m_stall) begin
      n_bad++;
      $display("FAIL perf ins=%h got=%0d/%0d want=%0d/%0d", ins, retired_cnt, stall_cnt, m_ret, m_stall);
    end
`else
    n_cmp++;
    if (retired_cnt !== '0 || stall_cnt !== '0) begin
      n_bad++;
      $display("FAIL perf_tied ins=%h got=%0d/%0d want=0/0", ins, retired_cnt, stall_cnt);
    end
`endif
  endtask

  task automatic test_reset;
    reset      = 1'b0;
    imem_valid = 1'b1;
    dmem_ready = 1'b1;
    Instr      = 32'hE0811002;
    ALUFlags   = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (state_o !== 3'd0 || {IRWrite, PCWrite, RegWrite, MemReq, MemWrite} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_state got=%0d/%b want=0/00000", state_o,
               {IRWrite, PCWrite, RegWrite, MemReq, MemWrite});
    end
    n_cmp++;
    if (retired_cnt !== '0 || stall_cnt !== '0) begin
      n_bad++;
      $display("FAIL reset_cnt got=%0d/%0d want=0/0", retired_cnt, stall_cnt);
    end
    reset      = 1'b1;
    imem_valid = 1'b0;
    m_nzcv     = 4'b0000;
    m_ret      = '0;
    m_stall    = 1;
  endtask

  task automatic test_flags_branch;
    int lat;
    do_instr(32'hE2921000, 0, 0, 4'b0100, lat);
    n_cmp++;
    if (lat != 4) begin n_bad++; $display("FAIL adds_latency got=%0d want=4", lat); end
    do_instr(32'h0A000000, 0, 0, 4'($urandom), lat);
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL beq_latency got=%0d want=3", lat); end
  endtask

  task automatic test_ldr_wait;
    int lat;
    do_instr(32'hE5910004, 0, 3, 4'($urandom), lat);
    n_cmp++;
    if (lat != 8) begin n_bad++; $display("FAIL ldr_latency got=%0d want=8", lat); end
  endtask

  task automatic test_str;
    int lat;
    do_instr(32'hE5810004, 0, 2, 4'($urandom), lat);
    n_cmp++;
    if (lat != 6) begin n_bad++; $display("FAIL str_latency got=%0d want=6", lat); end
  endtask

  task automatic test_cond_skip;
    int lat;
    do_instr(32'hE3510000, 0, 0, 4'b0100, lat);
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL cmp_latency got=%0d want=3", lat); end
    do_instr(32'h12811001, 0, 0, 4'($urandom), lat);
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL skip_latency got=%0d want=3", lat); end
  endtask

  task automatic test_bl;
    int lat;
    do_instr(32'hEB000000, 0, 0, 4'($urandom), lat);
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL bl_latency got=%0d want=3", lat); end
  endtask

  task automatic test_reset_in_mem;
    int lat;
    do_instr(32'hE3510000, 0, 0, 4'b0100, lat);
    @(negedge clk);
    Instr      = 32'hE5910004;
    imem_valid = 1'b1;
    dmem_ready = 1'b0;
    @(negedge clk);
    imem_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (state_o !== 3'd3 || MemReq !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_mem got=%0d/%b want=3/1", state_o, MemReq);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({MemReq, RegWrite, PCWrite} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_forced got=%b want=000", {MemReq, RegWrite, PCWrite});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (state_o !== 3'd0 || MemReq !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset got=%0d/%b want=0/0", state_o, MemReq);
    end
    m_nzcv  = 4'b0000;
    m_ret   = '0;
    m_stall = 1;
    do_instr(32'h0A000000, 0, 0, 4'($urandom), lat);
    n_cmp++;
    if (lat != 3) begin n_bad++; $display("FAIL flags_cleared_beq got=%0d want=3", lat); end
  endtask

  task automatic test_random;
    logic [31:0] ins;
    int          lat;
    for (int k = 0; k < 60; k++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 1) ins[31:28] = 4'hE;
      if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
      do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 4'($urandom), lat);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] tbl [9];
    int          lat;
    tbl = '{32'hE0811002, 32'hE2521001, 32'hE5910004, 32'hE5810008, 32'hEA000000,
            32'hEB000000, 32'hE1A0F002, 32'hE0211002, 32'hE3510000};
    for (int k = 0; k < 18; k++) begin
      do_instr({4'($urandom_range(0, 15)), tbl[k % 9][27:0]}, 0, 0, 4'($urandom), lat);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_flags_branch();
    test_ldr_wait();
    test_str();
    test_cond_skip();
    test_bl();
    test_reset_in_mem();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
